regfile_2r1w_clr: RTL
=====================

Name: regfile_2r1w_clr

Overview:
- Parametrised register file with one synchronous write port and two registered read ports.
- Adds byte-enable writes, write-to-read bypass, an optional hardwired zero register, and a sequential bulk-clear engine.
- It is the next generation of the 16x32 decoder/register/mux register file and sits between the instruction decode stage and the execute datapath.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0, if 1 register 0 always reads zero and writes to it are discarded.
- BYPASS, 1, if 1 a same-cycle write to the address being read is forwarded to the read result.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte enables; bit k covers wdata[8k+7:8k].
- re_a  in  1  read request, port A.
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  DATA_W  registered read data, port A.
- rvalid_a  out  1  rdata_a valid.
- re_b, raddr_b, rdata_b, rvalid_b: identical set for port B.
- clr_req  in  1  request to zero every register.
- busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (reset==0, asynchronous):
  - all DEPTH registers = 0;
  - rdata_a/b = 0, rvalid_a/b = 0;
  - busy = 0, clr_done = 0;
  - FSM = IDLE, sweep counter = 0.
  - Release is sampled on the next rising edge.
- Write, when we && !busy at a rising edge:
  - for each k with wbe[k]=1, reg[waddr] byte k <= wdata byte k; other bytes unchanged.
  - wbe == 0 means no change.
  - ZERO_REG=1 and waddr==0: write discarded.
- Read (each port independent, 1-cycle latency):
  - on a rising edge with re_x=1: rdata_x <= value(raddr_x), rvalid_x <= 1.
  - with re_x=0: rvalid_x <= 0 and rdata_x holds its previous value.
- value(addr):
  - ZERO_REG=1 and addr==0: 0.
  - else if BYPASS=1 and we && !busy && waddr==addr: the byte-merged result of the pending write.
  - else: current reg[addr].
  - With BYPASS=0 a same-cycle read returns the pre-write contents.
- Both ports may read the same address in the same cycle; both return the same value.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR, counter <= 0, busy <= 1.
  - CLEAR: each cycle reg[counter] <= 0, counter++. After writing index DEPTH-1 -> DONE. The counter wraps to 0 and must not be reused.
  - DONE: busy <= 0, clr_done <= 1 for exactly one cycle, then -> IDLE.
  - busy is high for exactly DEPTH cycles, beginning the cycle after clr_req is sampled.
  - Latency from clr_req to clr_done is DEPTH+1 cycles.
- Simultaneous events:
  - clr_req while busy or in DONE: ignored, no restart or queueing.
  - we while busy: dropped, with no error flag.
  - Reads while busy are serviced and return current contents, so a register may read as old data or as 0 depending on sweep progress.
  - we and clr_req in the same IDLE cycle: the write is performed and is then zeroed by the sweep.
- Reset mid-sweep: aborts immediately to the reset state; no clr_done pulse is issued.
- All address arithmetic is unsigned and modulo DEPTH. No out-of-range addresses exist.

Test Plan:
- Reset then read all 16 addresses on both ports -> every rdata = 0x00000000, rvalid high the cycle after each re.
- Write 0xDEADBEEF to r5 (wbe=0xF), then write 0x000000AA with wbe=0x1 -> next read of r5 returns 0xDEADBEAA.
- In one cycle write 0x12345678 to r3 with raddr_a=3 and raddr_b=3 -> with BYPASS=1 both ports return 0x12345678 next cycle; with BYPASS=0 both return the old r3 value.
- ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 -> returns 0; a read of r1 is unaffected.
- Fill r0..r15 with index*0x11111111, then pulse clr_req:
  - busy is high for 16 cycles and clr_done pulses once at cycle 17;
  - a we to r7 during busy is dropped;
  - a second clr_req during busy is ignored;
  - afterwards all registers read 0.
- Assert reset low at sweep cycle 8 -> all outputs 0 asynchronously, no clr_done pulse; after release, we/read work normally.

Source files
------------

// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr: 2-read/1-write register file with byte enables, bypass, optional zero register and bulk clear
module regfile_2r1w_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  re_a,
  input  logic [ADDR_W-1:0]     raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  output logic                  rvalid_a,
  input  logic                  re_b,
  input  logic [ADDR_W-1:0]     raddr_b,
  output logic [DATA_W-1:0]     rdata_b,
  output logic                  rvalid_b,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB = DATA_W/8;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, clr_done_q, clr_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic wr_en;
  logic [DATA_W-1:0] wmerge, val_a, val_b;
  // writes to a hardwired zero register are squashed here so neither storage nor bypass sees them
  assign wr_en = we && !busy_q && !(ZERO_REG != 0 && waddr == '0);
  always_comb begin
    wmerge = mem_q[waddr];
    for (int k = 0; k < NB; k++)
      if (wbe[k]) wmerge[8*k +: 8] = wdata[8*k +: 8];
  end
  assign val_a = (ZERO_REG != 0 && raddr_a == '0) ? '0 :
                 (BYPASS != 0 && wr_en && waddr == raddr_a) ? wmerge : mem_q[raddr_a];
  assign val_b = (ZERO_REG != 0 && raddr_b == '0) ? '0 :
                 (BYPASS != 0 && wr_en && waddr == raddr_b) ? wmerge : mem_q[raddr_b];
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[waddr] = wmerge;
    if (state_q == CLEAR) mem_d[cnt_q] = '0;
    state_d = state_q == IDLE  ? (clr_req ? CLEAR : IDLE) :
              state_q == CLEAR ? (cnt_q == ADDR_W'(DEPTH-1) ? DONE : CLEAR) : IDLE;
    cnt_d = state_q == CLEAR ? cnt_q + 1'b1 : '0;
    busy_d = state_d == CLEAR;
    clr_done_d = state_d == DONE;
    rdata_a_d = re_a ? val_a : rdata_a_q;
    rdata_b_d = re_b ? val_b : rdata_b_q;
    rvalid_a_d = re_a;
    rvalid_b_d = re_b;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      clr_done_q <= clr_done_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      mem_q <= mem_d;
    end
  end
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign busy = busy_q;
  assign clr_done = clr_done_q;
endmodule
